// File: rtl/pc_stack.sv
// pc_stack: instruction-fetch program counter with stall, PC-relative
// branches and a hardware return-address stack.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-low reset
//   stall       hold PC, stack and flags this cycle
//   branch      jump to target
//   call        jump to target and push return address (dout+INC)
//   ret         pop return address into PC
//   rel         1: target = dout + signed din, 0: target = din
//   din         branch/call target or two's-complement offset
//   dout        current PC to instruction memory (registered)
//   depth       return-address entries in use
//   stack_full  depth == STACK_DEPTH
//   stack_empty depth == 0
//   ovf         sticky: call while full
//   unf         sticky: ret while empty
//
// Edge priority: reset > stall > ret > call > branch > increment.
module pc_stack #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0,
  parameter int INC         = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             rel,
  input  logic [WIDTH-1:0]                 din,
  output logic [WIDTH-1:0]                 dout,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             ovf,
  output logic                             unf
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] tgt;
  logic [IW-1:0]    top_idx;
  logic [IW-1:0]    push_idx;
  logic             push_en;

  // Sum is WIDTH bits wide, so a negative offset wraps naturally.
  assign pc_inc = dout + WIDTH'(INC);
  assign tgt    = rel ? (dout + din) : din;

  // Top of stack lives at depth-1; the next free slot at depth.
  assign top_idx  = IW'(depth - DW'(1));
  assign push_idx = IW'(depth);

  assign stack_full  = (depth == DW'(STACK_DEPTH));
  assign stack_empty = (depth == '0);

  assign push_en = reset && !stall && !ret && call && !stack_full;

  // Stack contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (push_en) stack[push_idx] <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dout  <= WIDTH'(RESET_VEC);
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (!stall) begin
      if (ret) begin
        if (stack_empty) begin
          // Underflow falls through to the next sequential address.
          dout <= pc_inc;
          unf  <= 1'b1;
        end else begin
          dout  <= stack[top_idx];
          depth <= depth - DW'(1);
        end
      end else if (call) begin
        // The jump is taken even when the return address can't be saved.
        dout <= tgt;
        if (stack_full) ovf <= 1'b1;
        else            depth <= depth + DW'(1);
      end else if (branch) begin
        dout <= tgt;
      end else begin
        dout <= pc_inc;
      end
    end
  end

endmodule
